// File: rtl/instruction_sram_responder_pkg.sv
// Shared definitions for the instruction SRAM responder.
// Holds the fetch address width, the SRAM half-word width, the 2-bit FSM
// state encoding and the packed layout of a fetched instruction word.
package instruction_sram_responder_pkg;

  localparam int unsigned ADDRESS_LEN = 32;
  localparam int unsigned HALF_W      = 16;
  localparam int unsigned STATE_W     = 2;

  // Fetch sequencing states
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_READ_LO = 2'd1,
    ST_READ_HI = 2'd2,
    ST_DONE    = 2'd3
  } fetch_state_e;

  // Instruction assembled from two little-endian half-words
  typedef struct packed {
    logic [HALF_W-1:0] hi;
    logic [HALF_W-1:0] lo;
  } instr_halves_t;

endpackage

// File: rtl/instruction_sram_responder_if.sv
// Fetch-stage <-> responder handshake bundle.
//   fetch_req     : fetch stage requests the instruction at fetch_address
//   fetch_address : byte address (PC), bits [1:0] ignored
//   flush         : branch taken, abort any in-flight fetch
//   instruction   : fetched instruction, held until the next ready
//   ready         : one-cycle pulse, instruction valid
//   busy          : fetch_req & ~ready, drives the IF freeze input
// master = fetch stage, slave = responder.
interface instruction_sram_responder_if
  import instruction_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDRESS_LEN
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_address;
  logic              flush;
  logic [ADDR_W-1:0] instruction;
  logic              ready;
  logic              busy;

  modport master (
    output fetch_req,
    output fetch_address,
    output flush,
    input  instruction,
    input  ready,
    input  busy
  );

  modport slave (
    input  fetch_req,
    input  fetch_address,
    input  flush,
    output instruction,
    output ready,
    output busy
  );

endinterface

// File: rtl/instruction_sram_responder_sram_wait_counter.sv
// Counts the cycles spent on one SRAM half-word read.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count back to zero
//   en       : advance the count (wraps to zero after the terminal cycle)
//   last_c   : combinational, high on the final wait cycle of a half-word
module instruction_sram_responder_sram_wait_counter
  import instruction_sram_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last_c
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign last_c = (count == CNT_LAST);

  // Wrapping on the terminal cycle leaves the counter at zero for the next half
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= last_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_sram_responder.sv
// Instruction-fetch responder: turns a fetch-stage PC into a 32-bit
// instruction read as two half-words from a 16-bit external SRAM, with a
// one-entry last-fetch buffer so a frozen (repeated) PC needs no SRAM access.
//   clk, rst    : clock, synchronous active-high reset
//   fetch       : fetch handshake (slave side of instruction_sram_responder_if)
//   sram_addr   : SRAM half-word address
//   sram_rd_en  : SRAM read strobe, high while a half-word is being read
//   sram_rdata  : SRAM read data, sampled at the end of the last wait cycle
module instruction_sram_responder
  import instruction_sram_responder_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = ADDRESS_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_sram_responder_if.slave fetch,
  output logic [SRAM_ADDR_W-1:0]     sram_addr,
  output logic                       sram_rd_en,
  input  logic [HALF_W-1:0]          sram_rdata
);

  localparam int unsigned TAG_W  = ADDR_W - 2;
  localparam int unsigned WORD_W = SRAM_ADDR_W - 1;

  fetch_state_e      state;
  logic [TAG_W-1:0]  cap_tag;
  logic [TAG_W-1:0]  buf_tag;
  logic              buf_valid;
  logic [HALF_W-1:0] lo_half;
  logic [ADDR_W-1:0] instruction_q;
  logic              ready_q;

  logic [TAG_W-1:0]  req_tag_c;
  logic [WORD_W-1:0] req_word_c;
  logic [WORD_W-1:0] cap_word_c;
  logic              buf_hit_c;
  logic              wait_last_c;
  logic              wait_en_c;
  logic              wait_clear_c;
  instr_halves_t     new_instr_c;
  logic              unused_addr_lsbs;

  // Word-granular view of the request; the byte offset never matters
  assign req_tag_c        = fetch.fetch_address[ADDR_W-1:2];
  assign req_word_c       = req_tag_c[WORD_W-1:0];
  assign cap_word_c       = cap_tag[WORD_W-1:0];
  assign unused_addr_lsbs = ^fetch.fetch_address[1:0];

  // Buffer hit compares the full word address, not only the SRAM-visible bits
  assign buf_hit_c = buf_valid && (buf_tag == req_tag_c);

  assign new_instr_c = '{hi: sram_rdata, lo: lo_half};

  // Counter only runs while a half-word read is in progress
  assign wait_en_c    = (state == ST_READ_LO) || (state == ST_READ_HI);
  assign wait_clear_c = fetch.flush || !wait_en_c;

  instruction_sram_responder_sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (wait_clear_c),
    .en     (wait_en_c),
    .last_c (wait_last_c)
  );

  assign fetch.instruction = instruction_q;
  assign fetch.ready       = ready_q;
  assign fetch.busy        = fetch.fetch_req & ~ready_q;

  // Fetch sequencer; flush overrides every state and leaves buffer contents alone
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cap_tag       <= '0;
      buf_tag       <= '0;
      buf_valid     <= 1'b0;
      lo_half       <= '0;
      instruction_q <= '0;
      ready_q       <= 1'b0;
      sram_addr     <= '0;
      sram_rd_en    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (fetch.flush) begin
        state      <= ST_IDLE;
        sram_rd_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (fetch.fetch_req) begin
              if (buf_hit_c) begin
                state   <= ST_DONE;
                ready_q <= 1'b1;
              end else begin
                state      <= ST_READ_LO;
                cap_tag    <= req_tag_c;
                sram_addr  <= {req_word_c, 1'b0};
                sram_rd_en <= 1'b1;
              end
            end
          end
          ST_READ_LO: begin
            if (wait_last_c) begin
              lo_half   <= sram_rdata;
              sram_addr <= {cap_word_c, 1'b1};
              state     <= ST_READ_HI;
            end
          end
          ST_READ_HI: begin
            if (wait_last_c) begin
              instruction_q <= ADDR_W'(new_instr_c);
              buf_tag       <= cap_tag;
              buf_valid     <= 1'b1;
              sram_rd_en    <= 1'b0;
              ready_q       <= 1'b1;
              state         <= ST_DONE;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_sram_responder.sv
// Bench for instruction_sram_responder: two instances (1 and 3 wait cycles),
// directed scenarios followed by random traffic, every cycle compared with a
// transaction-level reference model.
module tb_instruction_sram_responder;
  import instruction_sram_responder_pkg::*;

  localparam int unsigned SAW = 18;
  localparam int unsigned AW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst           [2];
  logic          fetch_req     [2];
  logic [AW-1:0] fetch_address [2];
  logic          flush         [2];
  logic [SAW-1:0] sram_addr    [2];
  logic          sram_rd_en    [2];
  logic [15:0]   sram_rdata    [2];
  logic          obs_ready     [2];
  logic          obs_busy      [2];
  logic [AW-1:0] obs_instr     [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  // Reference model state
  int            m_mode  [2];   // 0 idle, 1 fetching, 2 delivering
  int            m_rem   [2];   // clock edges left until the instruction is delivered
  logic [29:0]   m_cap   [2];
  logic          m_tv    [2];
  logic [29:0]   m_tag   [2];
  logic [31:0]   m_instr [2];
  logic          m_ready [2];

  instruction_sram_responder_if #(.ADDR_W(AW)) fif0 ();
  instruction_sram_responder_if #(.ADDR_W(AW)) fif1 ();

  assign fif0.fetch_req     = fetch_req[0];
  assign fif0.fetch_address = fetch_address[0];
  assign fif0.flush         = flush[0];
  assign fif1.fetch_req     = fetch_req[1];
  assign fif1.fetch_address = fetch_address[1];
  assign fif1.flush         = flush[1];
  assign obs_ready[0] = fif0.ready;
  assign obs_busy[0]  = fif0.busy;
  assign obs_instr[0] = fif0.instruction;
  assign obs_ready[1] = fif1.ready;
  assign obs_busy[1]  = fif1.busy;
  assign obs_instr[1] = fif1.instruction;

  instruction_sram_responder #(.SRAM_ADDR_W(SAW), .WAIT_CYCLES(1), .ADDR_W(AW)) u_dut0 (
    .clk(clk), .rst(rst[0]), .fetch(fif0),
    .sram_addr(sram_addr[0]), .sram_rd_en(sram_rd_en[0]), .sram_rdata(sram_rdata[0])
  );

  instruction_sram_responder #(.SRAM_ADDR_W(SAW), .WAIT_CYCLES(3), .ADDR_W(AW)) u_dut1 (
    .clk(clk), .rst(rst[1]), .fetch(fif1),
    .sram_addr(sram_addr[1]), .sram_rd_en(sram_rd_en[1]), .sram_rdata(sram_rdata[1])
  );

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // SRAM contents: fixed words from the scenarios, a hash everywhere else
  function automatic logic [15:0] sram_val(input logic [SAW-1:0] a);
    logic [31:0] t;
    case (a)
      18'd2:   return 16'hBEEF;
      18'd3:   return 16'hDEAD;
      18'd8:   return 16'h5678;
      18'd9:   return 16'h1234;
      default: begin
        t = 32'(a) * 32'd40503;
        return t[23:8] ^ 16'h5A5A;
      end
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {sram_val({a[18:2], 1'b1}), sram_val({a[18:2], 1'b0})};
  endfunction

  assign sram_rdata[0] = sram_val(sram_addr[0]);
  assign sram_rdata[1] = sram_val(sram_addr[1]);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted miss delivers 2*W edges later, a hit one edge later
  task automatic model_step(input int k);
    int w;
    w = wait_of(k);
    if (rst[k]) begin
      m_mode[k] = 0; m_rem[k] = 0; m_tv[k] = 1'b0; m_instr[k] = '0; m_ready[k] = 1'b0;
    end else if (flush[k]) begin
      m_mode[k] = 0; m_ready[k] = 1'b0;
    end else if (m_mode[k] == 0) begin
      m_ready[k] = 1'b0;
      if (fetch_req[k]) begin
        if (m_tv[k] && m_tag[k] == fetch_address[k][31:2]) begin
          m_mode[k] = 2; m_ready[k] = 1'b1;
        end else begin
          m_mode[k] = 1; m_rem[k] = 2 * w; m_cap[k] = fetch_address[k][31:2];
        end
      end
    end else if (m_mode[k] == 1) begin
      m_rem[k]--;
      if (m_rem[k] == 0) begin
        m_instr[k] = exp_word({m_cap[k], 2'b00});
        m_tag[k] = m_cap[k]; m_tv[k] = 1'b1; m_mode[k] = 2; m_ready[k] = 1'b1;
      end
    end else begin
      m_mode[k] = 0; m_ready[k] = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // Per-cycle scoreboard, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        check_eq($sformatf("ready%0d", k), obs_ready[k], m_ready[k]);
        check_eq($sformatf("instr%0d", k), obs_instr[k], m_instr[k]);
        check_eq($sformatf("rd_en%0d", k), sram_rd_en[k], m_mode[k] == 1);
        check_eq($sformatf("busy%0d", k), obs_busy[k], fetch_req[k] & ~m_ready[k]);
        if (m_mode[k] == 1)
          check_eq($sformatf("sram_addr%0d", k), sram_addr[k],
                   {m_cap[k][16:0], (m_rem[k] <= wait_of(k))});
      end
    end
  end

  // Issue one request from an idle responder and measure its delivery
  task automatic do_fetch(input int k, input logic [31:0] a, input int exp_lat,
                          input logic [31:0] exp_instr, input int exp_halves, input string nm);
    int lat, lo_n, hi_n;
    logic [SAW-1:0] base;
    base = {a[18:2], 1'b0};
    lat = 0; lo_n = 0; hi_n = 0;
    fetch_req[k] = 1'b1;
    fetch_address[k] = a;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (sram_rd_en[k]) begin
        if (sram_addr[k] == base) lo_n++;
        else if (sram_addr[k] == (base | 18'd1)) hi_n++;
      end
      if (obs_ready[k]) begin
        lat = n;
        break;
      end
    end
    check_eq({nm, "_lat"}, lat, exp_lat);
    check_eq({nm, "_instr"}, obs_instr[k], exp_instr);
    check_eq({nm, "_lo_reads"}, lo_n, exp_halves);
    check_eq({nm, "_hi_reads"}, hi_n, exp_halves);
    @(posedge clk); #1;
    fetch_req[k] = 1'b0;
  endtask

  task automatic directed(input int k);
    int w;
    bit seen;
    w = wait_of(k);
    do_fetch(k, 32'h10, 2 * w + 1, 32'h1234_5678, w, "miss10");
    do_fetch(k, 32'h10, 1, 32'h1234_5678, 0, "hit10");

    // Flush while the high half is being read
    fetch_req[k] = 1'b1;
    fetch_address[k] = 32'h20;
    @(posedge clk);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sram_rd_en[k] && sram_addr[k][0]) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("flush_reach_hi", seen, 1'b1);
    #1 flush[k] = 1'b1;
    @(posedge clk); #1;
    flush[k] = 1'b0;
    fetch_req[k] = 1'b0;
    @(negedge clk);
    check_eq("flush_ready", obs_ready[k], 1'b0);
    check_eq("flush_rd_en", sram_rd_en[k], 1'b0);
    check_eq("flush_instr", obs_instr[k], 32'h1234_5678);
    @(posedge clk); #1;
    do_fetch(k, 32'h20, 2 * w + 1, exp_word(32'h20), w, "refetch20");
    do_fetch(k, 32'h04, 2 * w + 1, 32'hDEAD_BEEF, w, "miss04");

    // Reset during the low-half read; the buffered word must be forgotten
    fetch_req[k] = 1'b1;
    fetch_address[k] = 32'h40;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_lo", sram_rd_en[k] & ~sram_addr[k][0], 1'b1);
    #1 rst[k] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_no_ready", obs_ready[k], 1'b0);
      check_eq("rst_instr", obs_instr[k], 32'h0);
    end
    @(posedge clk); #1;
    rst[k] = 1'b0;
    do_fetch(k, 32'h04, 2 * w + 1, 32'hDEAD_BEEF, w, "miss04_after_rst");
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom % 6)
      0:       a = 32'h0000_0010;
      1:       a = 32'h0000_0020;
      2:       a = 32'h0000_0004;
      3:       a = 32'h0010_0010;   // same SRAM word as 0x10, different tag
      4:       a = 32'h0007_FFFC;   // top word of the SRAM
      default: a = $urandom;
    endcase
    return a | 32'($urandom % 4);
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; fetch_req[k] = 1'b1; fetch_address[k] = 32'h10; flush[k] = 1'b0;
    end
    @(posedge clk);
    armed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_ready", obs_ready[k], 1'b0);
      check_eq("reset_rd_en", sram_rd_en[k], 1'b0);
      check_eq("reset_instr", obs_instr[k], 32'h0);
      check_eq("reset_sram_addr", sram_addr[k], 18'h0);
      check_eq("reset_busy", obs_busy[k], 1'b1);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; fetch_req[k] = 1'b0;
    end

    directed(0);
    directed(1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]       = ($urandom % 150) == 0;
        flush[k]     = ($urandom % 12) == 0;
        fetch_req[k] = ($urandom % 4) != 0;
        if (($urandom % 3) == 0) fetch_address[k] = pick_addr();
      end
      @(posedge clk); #1;
    end

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; flush[k] = 1'b0; fetch_req[k] = 1'b0;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
